uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 16000000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: synchronous and active-low.
REQ-004 The block SHALL have port rx, input, 1, the asynchronous serial line, idle high.
REQ-005 The block SHALL have port bps_set, input, 2, the baud select: 00=9600, 01=19200, 10=38400, 11=115200.
REQ-006 The block SHALL have port dataout, output, 8, the last correctly received byte.
REQ-007 The block SHALL have port valid, output, 1, a one-cycle strobe when a new byte is on dataout.
REQ-008 The block SHALL have port frame_err, output, 1, a one-cycle strobe when a stop bit is sampled low.
REQ-009 The block SHALL have port busy, output, 1, high while a frame is being received.

Function
REQ-010 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), with no parity.
REQ-011 The bit period DIV SHALL be round(CLK_HZ/baud); at 16 MHz this gives 1667, 833, 417 and 139 clocks.
REQ-012 rx SHALL pass through a 2-flop synchronizer (rx_s) before use; no logic reads raw rx.
REQ-013 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-014 In IDLE, the FSM SHALL move to START on the first cycle in which rx_s is 0 after having been 1, and SHALL latch bps_set into an internal divisor register in that cycle.
REQ-015 The FSM SHALL ignore changes of bps_set until the next IDLE->START transition.
REQ-016 In START, the FSM SHALL wait DIV/2 clocks (integer division) and then sample rx_s.
REQ-017 On that START sample, a 0 SHALL move the FSM to DATA and a 1 SHALL return it to IDLE as a glitch, with no strobe.
REQ-018 In DATA, the FSM SHALL sample rx_s every DIV clocks, 8 times, shifting each bit into bit index 0..7 in order.
REQ-019 After the 8th data sample, the FSM SHALL move to STOP.
REQ-020 In STOP, the FSM SHALL sample rx_s after DIV clocks.
REQ-021 A stop sample of 1 SHALL register the shift byte to dataout and pulse valid high for exactly 1 cycle, in the cycle after the sample.
REQ-022 A stop sample of 0 SHALL pulse frame_err for 1 cycle and leave dataout unchanged.
REQ-023 After the STOP sample, the FSM SHALL return to IDLE (mid stop bit), so back-to-back frames are accepted without a gap.
REQ-024 After a frame error, a new frame SHALL start only once rx_s has been seen at 1 again; a held-low break yields exactly one frame_err.
REQ-025 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-026 valid and frame_err SHALL never be high in the same cycle.
REQ-027 The bit counter and the clock counter SHALL be sized for the largest DIV, with no wrap-around inside a bit period.

Reset
REQ-028 While rst_n=0 at a clk edge, the block SHALL set the state to IDLE, dataout=0x00, valid=0, frame_err=0 and busy=0, clear the counters and shift register, and set the synchronizer flops to 1.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no strobe; the first frame accepted afterwards is the one whose falling edge follows a seen-high rx_s.

Structure
REQ-030 A shared package uart_pkg SHALL hold the bps_set codes, the baud rates, the DIV derivation function and the rx state enum; uart_tx reuses the same codes and divisors.
REQ-031 The block SHALL contain one sub-module, uart_bit_timer, which takes the latched divisor, a load/half select and an enable, and produces a one-cycle tick at the end of the period.

Verification (clk 16 MHz, 62.5 ns)
REQ-032 A 38400 baud frame 0x93 from uart_tx into rx SHALL produce valid for 1 cycle, dataout=0x93 and frame_err=0, with busy falling within 3 clocks of valid.
REQ-033 A 19200 baud frame 0x9F followed immediately by 0x15 (no idle gap) SHALL produce two valid strobes, 0x9F then 0x15, spaced 10*833 +/-2 clocks.
REQ-034 A 200-clock low glitch on rx at 9600 baud SHALL produce no valid and no frame_err, with busy high for about 834 clocks and then 0.
REQ-035 A 9600 baud frame 0x15 with the stop bit forced to 0 SHALL produce one frame_err pulse and leave dataout at its previous value (0x93 after REQ-032).
REQ-036 rst_n pulsed low during data bit 4 of a 38400 baud frame SHALL drive all outputs to reset values with no strobe; the next clean frame 0xA5 SHALL be received correctly.
REQ-037 bps_set changed from 10 to 00 during data bit 2 SHALL still complete the frame at 38400 baud with correct data.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by uart_rx (and uart_tx):
//   - bps_set codes and the baud rate each code selects
//   - calc_div(): bit period in clocks, round(clk_hz / baud)
//   - div_width(): counter width that holds the slowest (largest) divisor
//   - rx_state_t: receiver FSM state encoding
// -----------------------------------------------------------------------------
package uart_pkg;

    // Baud select codes
    localparam logic [1:0] BPS_9600   = 2'b00;
    localparam logic [1:0] BPS_19200  = 2'b01;
    localparam logic [1:0] BPS_38400  = 2'b10;
    localparam logic [1:0] BPS_115200 = 2'b11;

    // Baud rates in bits per second
    localparam int BAUD_9600   = 9600;
    localparam int BAUD_19200  = 19200;
    localparam int BAUD_38400  = 38400;
    localparam int BAUD_115200 = 115200;

    // Receiver FSM states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Baud rate selected by a bps_set code
    function automatic int baud_of(input logic [1:0] code);
        case (code)
            BPS_9600:   return BAUD_9600;
            BPS_19200:  return BAUD_19200;
            BPS_38400:  return BAUD_38400;
            default:    return BAUD_115200;
        endcase
    endfunction

    // Bit period in clocks, rounded to nearest
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    // Width of a counter able to hold the largest divisor (slowest baud)
    function automatic int div_width(input int clk_hz);
        return $clog2(calc_div(clk_hz, BAUD_9600) + 1);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Down-counter producing a one-cycle tick at the end of each bit period.
// A load starts a new period (half or full length); while enabled the timer
// then auto-reloads a full period after every tick.
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   synchronous active-low reset
//   i_div   in   [W]  bit period in clocks
//   i_load  in   start a new period this cycle
//   i_half  in   with i_load: first period is i_div/2 instead of i_div
//   i_en    in   count enable
//   o_tick  out  one-cycle strobe at the end of the current period
// -----------------------------------------------------------------------------
module uart_bit_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_div,
    input  logic         i_load,
    input  logic         i_half,
    input  logic         i_en,
    output logic         o_tick
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_first;

    assign w_first = i_half ? (i_div >> 1) : i_div;

    // A count of N means N more cycles remain before the tick cycle
    assign o_tick = i_en && !i_load && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= w_first - W'(1);
        end else if (i_en) begin
            if (r_cnt == '0) begin
                r_cnt <= i_div - W'(1);
            end else begin
                r_cnt <= r_cnt - W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with run-time baud select. The line is synchronised by
// two flops, the start bit is qualified at its centre and every following
// bit is sampled one bit period later.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   rx         in   asynchronous serial line, idle high
//   bps_set    in   [2] baud select: 00=9600 01=19200 10=38400 11=115200
//   dataout    out  [8] last correctly received byte
//   valid      out  one-cycle strobe, new byte on dataout
//   frame_err  out  one-cycle strobe, stop bit sampled low
//   busy       out  high while a frame is being received
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 16000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic [1:0] bps_set,
    output logic [7:0] dataout,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV_W = div_width(CLK_HZ);

    localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(calc_div(CLK_HZ, BAUD_9600));
    localparam logic [DIV_W-1:0] DIV_19200  = DIV_W'(calc_div(CLK_HZ, BAUD_19200));
    localparam logic [DIV_W-1:0] DIV_38400  = DIV_W'(calc_div(CLK_HZ, BAUD_38400));
    localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'(calc_div(CLK_HZ, BAUD_115200));

    logic [1:0]       r_sync;      // [1] is the synchronised line rx_s
    logic             w_rx_s;
    rx_state_t        r_state;
    logic             r_armed;     // line seen high since the last frame
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_lut;
    logic [DIV_W-1:0] w_div_use;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_dataout;
    logic             r_valid;
    logic             r_frame_err;
    logic             w_start;
    logic             w_half;
    logic             w_en;
    logic             w_tick;

    assign w_rx_s = r_sync[1];

    always_comb begin
        w_div_lut = DIV_115200;
        case (bps_set)
            BPS_9600:   w_div_lut = DIV_9600;
            BPS_19200:  w_div_lut = DIV_19200;
            BPS_38400:  w_div_lut = DIV_38400;
            default:    w_div_lut = DIV_115200;
        endcase
    end

    // A start needs a high-to-low transition; a line held low after a frame
    // error therefore cannot retrigger until it has gone high again.
    assign w_start = (r_state == RX_IDLE) && r_armed && !w_rx_s;

    // The divisor is latched on the start cycle, so the timer takes the
    // live selection in that one cycle and the latched value afterwards.
    assign w_div_use = (r_state == RX_IDLE) ? w_div_lut : r_div;
    assign w_half    = (r_state == RX_IDLE);
    assign w_en      = (r_state != RX_IDLE);

    uart_bit_timer #(
        .W (DIV_W)
    ) u_bit_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_div  (w_div_use),
        .i_load (w_start),
        .i_half (w_half),
        .i_en   (w_en),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= RX_IDLE;
            r_armed     <= 1'b0;
            r_div       <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_dataout   <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (w_start) begin
                        r_state   <= RX_START;
                        r_div     <= w_div_lut;
                        r_armed   <= 1'b0;
                        r_bit_cnt <= '0;
                    end else if (w_rx_s) begin
                        r_armed <= 1'b1;
                    end
                end
                RX_START: begin
                    if (w_tick) begin
                        if (w_rx_s) begin
                            // Start bit gone by mid-bit: treat as a glitch
                            r_state <= RX_IDLE;
                            r_armed <= 1'b1;
                        end else begin
                            r_state <= RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_tick) begin
                        // LSB arrives first, so shift in from the top
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_state   <= RX_STOP;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (w_tick) begin
                        // Back to idle mid stop bit so the next start edge
                        // can follow immediately.
                        r_state <= RX_IDLE;
                        r_armed <= w_rx_s;
                        if (w_rx_s) begin
                            r_dataout <= r_shift;
                            r_valid   <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= RX_IDLE;
                end
            endcase
        end
    end

    assign dataout   = r_dataout;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Drives 8N1 frames onto rx at 16 MHz and checks uart_rx against a frame-level
// model: each transmitted frame queues the strobe it must produce (kind, byte,
// and the nominal cycle = start edge + DIV/2 + 9*DIV). A compare process
// checks every cycle's strobes, dataout and busy against that queue.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [1:0] bps_set;
    logic [7:0] dataout;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(
        .CLK_HZ (16000000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .bps_set   (bps_set),
        .dataout   (dataout),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #31.25 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         nom;
    } ev_t;

    ev_t  exp_q[$];
    int   valid_cycs[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic [7:0] model_data = 8'h00;
    int   n_valid_seen  = 0;
    int   n_ferr_seen   = 0;
    int   busy_run      = 0;
    int   last_busy_len = 0;
    int   strobe_cyc    = -1;
    bit   prev_valid    = 1'b0;
    bit   prev_ferr     = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // Bit period in clocks at 16 MHz for each baud code
    function automatic int bench_div(input logic [1:0] code);
        case (code)
            2'b00:   return 1667;
            2'b01:   return 833;
            2'b10:   return 417;
            default: return 139;
        endcase
    endfunction

    // Advance n rising edges, then step just past the edge
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------------
    // Compare process: runs on the falling edge, away from the active edge
    // ---------------------------------------------------------------------
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                model_data = 8'h00;
                exp_q.delete();
                prev_valid = 1'b0;
                prev_ferr  = 1'b0;
                busy_run   = 0;
                strobe_cyc = -1;
            end else begin
                check("strobe_exclusive", int'(valid && frame_err), 0);
                check("valid_width", int'(valid && prev_valid), 0);
                check("ferr_width", int'(frame_err && prev_ferr), 0);
                if (valid || frame_err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", int'({valid, frame_err}), 0);
                    end else begin
                        ev = exp_q.pop_front();
                        check("strobe_kind_ferr", int'(frame_err), int'(ev.is_err));
                        check_range("strobe_time", cyc, ev.nom + 2, ev.nom + 6);
                        if (valid) begin
                            check("dataout_on_valid", int'(dataout), int'(ev.data));
                            model_data = ev.data;
                            n_valid_seen++;
                            valid_cycs.push_back(cyc);
                        end else begin
                            check("dataout_on_ferr", int'(dataout), int'(model_data));
                            n_ferr_seen++;
                        end
                        $display("strobe cyc=%0d valid=%0b ferr=%0b dataout=0x%02h", cyc, valid, frame_err, dataout);
                    end
                    strobe_cyc = cyc;
                end else begin
                    check("dataout_hold", int'(dataout), int'(model_data));
                end
                while (exp_q.size() > 0 && cyc > exp_q[0].nom + 6) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL strobe_missing: no strobe by cycle %0d, expected near %0d (data 0x%02h)", cyc, exp_q[0].nom, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
                if (strobe_cyc >= 0 && cyc == strobe_cyc + 3) begin
                    check("busy_after_strobe", int'(busy), 0);
                end
                if (busy) begin
                    busy_run++;
                end else if (busy_run > 0) begin
                    last_busy_len = busy_run;
                    busy_run = 0;
                end
                prev_valid = valid;
                prev_ferr  = frame_err;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_cycles(3);
        check("rst_dataout", int'(dataout), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
    endtask

    // Send one frame. abort_bit>=0 resets the DUT mid data bit; chg_bit>=0
    // switches bps_set to 9600 at that data bit; hold_low extends a low stop.
    task automatic send_frame(input logic [1:0] code, input logic [7:0] data,
                              input logic stop_bit, input int abort_bit,
                              input int chg_bit, input int hold_low);
        int  div;
        ev_t ev;
        div     = bench_div(code);
        bps_set = code;
        rx      = 1'b0;
        if (abort_bit < 0) begin
            ev.is_err = !stop_bit;
            ev.data   = data;
            ev.nom    = cyc + div / 2 + 9 * div;
            exp_q.push_back(ev);
        end
        $display("send code=%0d data=0x%02h stop=%0b abort=%0d chg=%0d cyc=%0d", code, data, stop_bit, abort_bit, chg_bit, cyc);
        wait_cycles(div);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            if (i == chg_bit) bps_set = 2'b00;
            if (i == abort_bit) begin
                wait_cycles(div / 2);
                do_reset();
                return;
            end
            if (i == 4) begin
                wait_cycles(div / 2);
                check("busy_mid_frame", int'(busy), 1);
                wait_cycles(div - div / 2);
            end else begin
                wait_cycles(div);
            end
        end
        rx = stop_bit;
        wait_cycles(div);
        if (hold_low > 0) wait_cycles(hold_low);
        rx = 1'b1;
    endtask

    initial begin
        int n_v;
        int n_f;
        rst_n   = 1'b0;
        rx      = 1'b1;
        bps_set = 2'b10;
        wait_cycles(5);
        check("init_dataout", int'(dataout), 0);
        check("init_valid", int'(valid), 0);
        check("init_frame_err", int'(frame_err), 0);
        check("init_busy", int'(busy), 0);
        rst_n = 1'b1;
        wait_cycles(20);

        // 38400 baud 0x93
        send_frame(2'b10, 8'h93, 1'b1, -1, -1, 0);
        wait_cycles(200);
        check("b38400_dataout", int'(dataout), 8'h93);
        check("b38400_nvalid", n_valid_seen, 1);

        // 9600 baud 0x15 with stop bit low: one frame_err, dataout kept
        send_frame(2'b00, 8'h15, 1'b0, -1, -1, 0);
        wait_cycles(200);
        check("ferr_count", n_ferr_seen, 1);
        check("ferr_dataout_kept", int'(dataout), 8'h93);

        // 19200 baud back-to-back 0x9F, 0x15
        send_frame(2'b01, 8'h9F, 1'b1, -1, -1, 0);
        send_frame(2'b01, 8'h15, 1'b1, -1, -1, 0);
        wait_cycles(200);
        check("b2b_nvalid", n_valid_seen, 3);
        check_range("b2b_spacing", valid_cycs[valid_cycs.size()-1] - valid_cycs[valid_cycs.size()-2], 8328, 8332);
        check("b2b_dataout", int'(dataout), 8'h15);

        // 200-clock low glitch at 9600
        n_v = n_valid_seen;
        n_f = n_ferr_seen;
        bps_set = 2'b00;
        rx = 1'b0;
        wait_cycles(200);
        rx = 1'b1;
        wait_cycles(1200);
        $display("glitch busy_len=%0d", last_busy_len);
        check_range("glitch_busy_len", last_busy_len, 831, 837);
        check("glitch_no_valid", n_valid_seen, n_v);
        check("glitch_no_ferr", n_ferr_seen, n_f);
        check("glitch_busy_low", int'(busy), 0);

        // Break at 115200: line held low for many frames gives one frame_err
        send_frame(2'b11, 8'h00, 1'b0, -1, -1, 3 * 10 * 139);
        wait_cycles(300);
        check("break_ferr_count", n_ferr_seen, 2);
        check("break_busy_low", int'(busy), 0);

        // Recovery frame at 115200
        send_frame(2'b11, 8'h3C, 1'b1, -1, -1, 0);
        wait_cycles(100);
        check("b115200_dataout", int'(dataout), 8'h3C);

        // Reset during data bit 4 at 38400, then a clean 0xA5
        n_v = n_valid_seen;
        send_frame(2'b10, 8'hE7, 1'b1, 4, -1, 0);
        wait_cycles(12 * 417);
        check("abort_no_valid", n_valid_seen, n_v);
        check("abort_dataout", int'(dataout), 0);
        send_frame(2'b10, 8'hA5, 1'b1, -1, -1, 0);
        wait_cycles(200);
        check("after_reset_dataout", int'(dataout), 8'hA5);

        // bps_set changed to 9600 during data bit 2 of a 38400 frame
        send_frame(2'b10, 8'h6B, 1'b1, -1, 2, 0);
        wait_cycles(200);
        check("bps_change_dataout", int'(dataout), 8'h6B);

        wait_cycles(20);
        check("final_pending", exp_q.size(), 0);
        check("final_nvalid", n_valid_seen, 6);
        check("final_nferr", n_ferr_seen, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
